fht_stage_ctrl: RTL and testbench
=================================

Name: fht_stage_ctrl

Overview:
Sequencer for the radix-2 Hartley butterfly (fht_but) over an N = 2^N_LOG point transform held in two ping-pong memory banks. Per stage it walks every butterfly, issuing three read addresses (x0, x1, x2), a twiddle (sin/cos ROM) index and, after the butterfly pipeline latency, two write-back addresses with a write enable. It sits between the top-level start/done handshake and the sample memories, twiddle ROM and butterfly.

Parameters:
N_LOG, 4, log2 of transform length; N = 2^N_LOG, N/2 butterflies per stage, N_LOG stages.
LAT, 1, butterfly latency in clocks from operands valid to oY_0/oY_1 valid (>= 1).
S_BIT, 3, stage counter width; must satisfy 2^S_BIT > N_LOG-1.

Ports:
iCLK  in  1  clock, all logic on rising edge.
iRESET  in  1  synchronous, active-high reset.
iSTART  in  1  start request; sampled only in IDLE.
oBUSY  out  1  high from the first RUN cycle until the DONE cycle (exclusive).
oDONE  out  1  one-cycle pulse: transform complete.
oSTAGE  out  S_BIT  current stage s.
oRD_VALID  out  1  read addresses/twiddle valid this cycle.
oRD_BANK  out  1  bank read this stage (= s[0]).
oRD_ADDR_0  out  N_LOG  x0 address.
oRD_ADDR_1  out  N_LOG  x1 address.
oRD_ADDR_2  out  N_LOG  x2 address.
oTW_ADDR  out  N_LOG-1  twiddle index into an N-entry-angle table (angle = 2*pi*idx/N).
oWE  out  1  write enable for y0/y1.
oWR_BANK  out  1  bank written (= ~read bank of the issuing stage).
oWR_ADDR_0  out  N_LOG  y0 address.
oWR_ADDR_1  out  N_LOG  y1 address.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. All outputs registered.
- Reset (synchronous, iRESET=1 at edge): state IDLE, s=0, b=0, delay line cleared; all outputs 0. Reset mid-operation aborts immediately: oWE=0 from the next cycle, no oDONE, no further writes.
- IDLE: iSTART=1 -> RUN with s=0, b=0. iSTART in any other state is ignored (no queuing).
- RUN: oBUSY=1, oRD_VALID=1, one butterfly per cycle, b increments. After b=N/2-1 is issued -> DRAIN.
- Address arithmetic for stage s, butterfly b: half=2^s; g=b>>s; k=b&(half-1); base=g*2*half.
  RD_ADDR_0=base+k; RD_ADDR_1=base+half+k; RD_ADDR_2=base+half+((half-k) mod half) (k=0 gives RD_ADDR_1); TW_ADDR=k<<(N_LOG-1-s). All unsigned, no wrap beyond N-1.
- Write path: RD_ADDR_0/1 and bank delayed by exactly LAT cycles through a shift register; oWE = oRD_VALID delayed LAT cycles; oWR_ADDR_0/1 = delayed RD_ADDR_0/1; oWR_BANK = ~delayed oRD_BANK.
- DRAIN: oRD_VALID=0, held exactly LAT cycles (last write completes on final DRAIN cycle). Then: s<N_LOG-1 -> s++, b=0, RUN (bank flips); s=N_LOG-1 -> DONE.
- DONE: one cycle, oDONE=1, oBUSY=0, oWE=0; -> IDLE. iSTART on the DONE cycle is ignored.
- Per stage: N/2 RUN + LAT DRAIN cycles; oBUSY high N_LOG*(N/2+LAT) cycles total. No read/write overlap on a bank within a stage; no cross-stage hazard because the next stage's first read follows the last write.
- Result resides in bank N_LOG[0] (bank 0 if N_LOG even).

Test Plan:
- Reset then iSTART pulse (N_LOG=4, LAT=1) -> oBUSY high exactly 36 cycles, oDONE single pulse on the cycle after oBUSY falls, 32 oWE cycles total.
- Stage 0 trace -> b=0..7: RD_ADDR_0=2b, RD_ADDR_1=RD_ADDR_2=2b+1, TW_ADDR=0, oRD_BANK=0; oWE with WR_ADDR_0=2b one cycle later, oWR_BANK=1.
- Stage 2, b=5 -> RD_ADDR_0=9, RD_ADDR_1=13, RD_ADDR_2=15, TW_ADDR=2, oSTAGE=2, oRD_BANK=0.
- iSTART held high throughout, and pulsed mid-RUN -> exactly one transform, no restart; new run only after IDLE reached.
- iRESET asserted for one cycle in stage 1, b=3 -> next cycle all outputs 0, state IDLE, no oDONE; later iSTART runs a full clean 36-cycle transform.
- LAT=3 build -> each DRAIN 3 cycles, oBUSY 44 cycles, every write address equals read address issued 3 cycles earlier.

Source files
------------

// File: rtl/fht_stage_ctrl_if.sv
// Handshake and memory-address bundle between the FHT stage sequencer and
// its surroundings (start/done host, ping-pong sample banks, twiddle ROM).
interface fht_stage_ctrl_if #(
  parameter int N_LOG = 4,
  parameter int S_BIT = 3
);
  logic             iSTART;
  logic             oBUSY;
  logic             oDONE;
  logic [S_BIT-1:0] oSTAGE;
  logic             oRD_VALID;
  logic             oRD_BANK;
  logic [N_LOG-1:0] oRD_ADDR_0;
  logic [N_LOG-1:0] oRD_ADDR_1;
  logic [N_LOG-1:0] oRD_ADDR_2;
  logic [N_LOG-2:0] oTW_ADDR;
  logic             oWE;
  logic             oWR_BANK;
  logic [N_LOG-1:0] oWR_ADDR_0;
  logic [N_LOG-1:0] oWR_ADDR_1;

  modport master (
    output iSTART,
    input  oBUSY, oDONE, oSTAGE, oRD_VALID, oRD_BANK,
    input  oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
    input  oWE, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1
  );

  modport slave (
    input  iSTART,
    output oBUSY, oDONE, oSTAGE, oRD_VALID, oRD_BANK,
    output oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
    output oWE, oWR_BANK, oWR_ADDR_0, oWR_ADDR_1
  );
endinterface

// File: rtl/fht_stage_ctrl.sv
// Stage/butterfly sequencer for a radix-2 Hartley transform over ping-pong banks.
//
// state | meaning
// IDLE  | waiting for iSTART
// RUN   | issuing one butterfly per cycle (reads + twiddle)
// DRAIN | LAT cycles letting the butterfly pipeline write back
// DONE  | one-cycle completion pulse, start ignored
module fht_stage_ctrl #(
  parameter int N_LOG = 4,
  parameter int LAT   = 1,
  parameter int S_BIT = 3
) (
  input logic          iCLK,
  input logic          iRESET,
  fht_stage_ctrl_if.slave bus
);
  localparam int AW = N_LOG;
  localparam int TW = N_LOG - 1;
  localparam int NB = 1 << (N_LOG - 1);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [S_BIT-1:0] s, s_n;
  logic [TW-1:0]    b, b_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_n, done_n, rdv_n;

  logic [AW-1:0]    b_ext, half, k, base;
  logic [AW-1:0]    a0_n, a1_n, a2_n;
  logic [TW-1:0]    tw_n;
  logic [S_BIT-1:0] tw_sh;

  logic             busy_q, done_q, rdv_q, rd_bank_q;
  logic [S_BIT-1:0] stage_q;
  logic [AW-1:0]    a0_q, a1_q, a2_q;
  logic [TW-1:0]    tw_q;

  logic             pv  [1:LAT];
  logic             pb  [1:LAT];
  logic [AW-1:0]    pa0 [1:LAT];
  logic [AW-1:0]    pa1 [1:LAT];

  // next-state, counters and the flags for the cycle being entered
  always_comb begin
    state_n = state;
    s_n     = s;
    b_n     = b;
    cnt_n   = cnt;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    rdv_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.iSTART) begin
          state_n = RUN;
          s_n     = '0;
          b_n     = '0;
          busy_n  = 1'b1;
          rdv_n   = 1'b1;
        end
      end
      RUN: begin
        busy_n = 1'b1;
        if (b == TW'(NB - 1)) begin
          state_n = DRAIN;
          cnt_n   = CW'(LAT - 1);
        end else begin
          b_n   = b + 1'b1;
          rdv_n = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          if (s == S_BIT'(N_LOG - 1)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            s_n     = s + 1'b1;
            b_n     = '0;
            busy_n  = 1'b1;
            rdv_n   = 1'b1;
          end
        end else begin
          cnt_n  = cnt - 1'b1;
          busy_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        s_n     = '0;
        b_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // butterfly addressing for the (stage, butterfly) pair about to be issued
  always_comb begin
    b_ext = {1'b0, b_n};
    half  = AW'(1) << s_n;
    k     = b_ext & (half - AW'(1));
    base  = ((b_ext >> s_n) << s_n) << 1;
    a0_n  = base + k;
    a1_n  = base + half + k;
    // mirror partner within the upper half; k=0 folds onto itself
    a2_n  = base + half + ((half - k) & (half - AW'(1)));
    tw_sh = S_BIT'(N_LOG - 1) - s_n;
    tw_n  = TW'(k << tw_sh);
  end

  // state register plus registered read-side outputs
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state     <= IDLE;
      s         <= '0;
      b         <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdv_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      stage_q   <= '0;
      a0_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      tw_q      <= '0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      b         <= b_n;
      cnt       <= cnt_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      rdv_q     <= rdv_n;
      rd_bank_q <= s_n[0];
      stage_q   <= s_n;
      a0_q      <= rdv_n ? a0_n : '0;
      a1_q      <= rdv_n ? a1_n : '0;
      a2_q      <= rdv_n ? a2_n : '0;
      tw_q      <= rdv_n ? tw_n : '0;
    end
  end

  // write-back delay line matching the butterfly latency; bank stored pre-inverted
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 1; i <= LAT; i++) begin
        pv[i]  <= 1'b0;
        pb[i]  <= 1'b0;
        pa0[i] <= '0;
        pa1[i] <= '0;
      end
    end else begin
      for (int i = LAT; i >= 2; i--) begin
        pv[i]  <= pv[i-1];
        pb[i]  <= pb[i-1];
        pa0[i] <= pa0[i-1];
        pa1[i] <= pa1[i-1];
      end
      pv[1]  <= rdv_q;
      pb[1]  <= rdv_q & ~rd_bank_q;
      pa0[1] <= a0_q;
      pa1[1] <= a1_q;
    end
  end

  assign bus.oBUSY      = busy_q;
  assign bus.oDONE      = done_q;
  assign bus.oSTAGE     = stage_q;
  assign bus.oRD_VALID  = rdv_q;
  assign bus.oRD_BANK   = rd_bank_q;
  assign bus.oRD_ADDR_0 = a0_q;
  assign bus.oRD_ADDR_1 = a1_q;
  assign bus.oRD_ADDR_2 = a2_q;
  assign bus.oTW_ADDR   = tw_q;
  assign bus.oWE        = pv[LAT];
  assign bus.oWR_BANK   = pb[LAT];
  assign bus.oWR_ADDR_0 = pa0[LAT];
  assign bus.oWR_ADDR_1 = pa1[LAT];
endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Bench for fht_stage_ctrl: one LAT=1 and one LAT=3 instance, each compared
// cycle by cycle against a trace built from the transform's addressing rules.
module tb_fht_stage_ctrl;
  localparam int N_LOG = 4;
  localparam int S_BIT = 3;
  localparam int NB    = 1 << (N_LOG - 1);

  typedef struct {
    bit valid;
    int stage;
    int b;
    int a0, a1, a2, tw;
  } rec_t;

  typedef struct {
    logic busy, done, rd_valid, rd_bank, we, wr_bank;
    logic [S_BIT-1:0] stage;
    logic [N_LOG-1:0] a0, a1, a2, w0, w1;
    logic [N_LOG-2:0] tw;
  } obs_t;

  logic clk;
  logic rst1, rst3;
  int   errors = 0;
  int   checks = 0;

  fht_stage_ctrl_if #(.N_LOG(N_LOG), .S_BIT(S_BIT)) bus1 ();
  fht_stage_ctrl_if #(.N_LOG(N_LOG), .S_BIT(S_BIT)) bus3 ();

  fht_stage_ctrl #(.N_LOG(N_LOG), .LAT(1), .S_BIT(S_BIT)) dut1 (
    .iCLK(clk), .iRESET(rst1), .bus(bus1.slave)
  );
  fht_stage_ctrl #(.N_LOG(N_LOG), .LAT(3), .S_BIT(S_BIT)) dut3 (
    .iCLK(clk), .iRESET(rst3), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int which, output obs_t o);
    if (which == 1) begin
      o.busy = bus1.oBUSY; o.done = bus1.oDONE; o.stage = bus1.oSTAGE;
      o.rd_valid = bus1.oRD_VALID; o.rd_bank = bus1.oRD_BANK;
      o.a0 = bus1.oRD_ADDR_0; o.a1 = bus1.oRD_ADDR_1; o.a2 = bus1.oRD_ADDR_2;
      o.tw = bus1.oTW_ADDR; o.we = bus1.oWE; o.wr_bank = bus1.oWR_BANK;
      o.w0 = bus1.oWR_ADDR_0; o.w1 = bus1.oWR_ADDR_1;
    end else begin
      o.busy = bus3.oBUSY; o.done = bus3.oDONE; o.stage = bus3.oSTAGE;
      o.rd_valid = bus3.oRD_VALID; o.rd_bank = bus3.oRD_BANK;
      o.a0 = bus3.oRD_ADDR_0; o.a1 = bus3.oRD_ADDR_1; o.a2 = bus3.oRD_ADDR_2;
      o.tw = bus3.oTW_ADDR; o.we = bus3.oWE; o.wr_bank = bus3.oWR_BANK;
      o.w0 = bus3.oWR_ADDR_0; o.w1 = bus3.oWR_ADDR_1;
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 1) bus1.iSTART = v;
    else            bus3.iSTART = v;
  endtask

  task automatic set_rst(input int which, input logic v);
    if (which == 1) rst1 = v;
    else            rst3 = v;
  endtask

  // reference addressing straight from the stage/butterfly arithmetic
  function automatic rec_t model_rec(input int s, input int b);
    rec_t r;
    int half, g, k, base;
    half = 1 << s;
    g    = b / half;
    k    = b % half;
    base = g * 2 * half;
    r.valid = 1'b1;
    r.stage = s;
    r.b     = b;
    r.a0    = base + k;
    r.a1    = base + half + k;
    r.a2    = base + half + ((half - k) % half);
    r.tw    = k * (1 << (N_LOG - 1 - s));
    return r;
  endfunction

  task automatic zero_chk(input int which, input string tag);
    obs_t o;
    sample(which, o);
    chk({tag, " busy"},     o.busy, 0);
    chk({tag, " done"},     o.done, 0);
    chk({tag, " stage"},    o.stage, 0);
    chk({tag, " rd_valid"}, o.rd_valid, 0);
    chk({tag, " rd_bank"},  o.rd_bank, 0);
    chk({tag, " rd_addr0"}, o.a0, 0);
    chk({tag, " rd_addr1"}, o.a1, 0);
    chk({tag, " rd_addr2"}, o.a2, 0);
    chk({tag, " tw_addr"},  o.tw, 0);
    chk({tag, " we"},       o.we, 0);
    chk({tag, " wr_bank"},  o.wr_bank, 0);
    chk({tag, " wr_addr0"}, o.w0, 0);
    chk({tag, " wr_addr1"}, o.w1, 0);
  endtask

  task automatic idle_chk(input int which, input int n, input string tag);
    obs_t o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sample(which, o);
      chk($sformatf("%s idle%0d busy", tag, i), o.busy, 0);
      chk($sformatf("%s idle%0d done", tag, i), o.done, 0);
      chk($sformatf("%s idle%0d we", tag, i), o.we, 0);
      chk($sformatf("%s idle%0d rd_valid", tag, i), o.rd_valid, 0);
    end
  endtask

  // mode 0: start pulse only; 1: start held high; 2: start random during the run
  task automatic run_xform(input int which, input int lat, input int mode, input int abort_at);
    rec_t  q[$];
    rec_t  e, w;
    rec_t  r;
    obs_t  o;
    int    total;
    int    busy_cnt;
    int    we_cnt;
    string t;
    busy_cnt = 0;
    we_cnt   = 0;
    for (int s = 0; s < N_LOG; s++) begin
      for (int b = 0; b < NB; b++) q.push_back(model_rec(s, b));
      for (int d = 0; d < lat; d++) begin
        r = '{valid: 1'b0, stage: s, b: 0, a0: 0, a1: 0, a2: 0, tw: 0};
        q.push_back(r);
      end
    end
    total = q.size();
    set_start(which, 1'b1);
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      sample(which, o);
      e = q[c];
      t = $sformatf("L%0d c%0d s%0d b%0d", lat, c, e.stage, e.b);
      chk({t, " busy"}, o.busy, 1);
      chk({t, " done"}, o.done, 0);
      chk({t, " stage"}, o.stage, e.stage);
      chk({t, " rd_valid"}, o.rd_valid, e.valid);
      if (e.valid) begin
        chk({t, " rd_bank"}, o.rd_bank, e.stage % 2);
        chk({t, " rd_addr0"}, o.a0, e.a0);
        chk({t, " rd_addr1"}, o.a1, e.a1);
        chk({t, " rd_addr2"}, o.a2, e.a2);
        chk({t, " tw_addr"}, o.tw, e.tw);
        if (e.stage == 0) begin
          chk({t, " s0 rd_addr0"}, o.a0, 2 * e.b);
          chk({t, " s0 rd_addr2"}, o.a2, 2 * e.b + 1);
          chk({t, " s0 tw_addr"}, o.tw, 0);
        end
        if (e.stage == 2 && e.b == 5) begin
          chk({t, " s2b5 rd_addr0"}, o.a0, 9);
          chk({t, " s2b5 rd_addr1"}, o.a1, 13);
          chk({t, " s2b5 rd_addr2"}, o.a2, 15);
          chk({t, " s2b5 tw_addr"}, o.tw, 2);
        end
      end
      if (c >= lat && q[c-lat].valid) begin
        w = q[c-lat];
        chk({t, " we"}, o.we, 1);
        chk({t, " wr_addr0"}, o.w0, w.a0);
        chk({t, " wr_addr1"}, o.w1, w.a1);
        chk({t, " wr_bank"}, o.wr_bank, 1 - (w.stage % 2));
      end else begin
        chk({t, " we"}, o.we, 0);
      end
      busy_cnt += int'(o.busy);
      we_cnt   += int'(o.we);
      case (mode)
        0:       set_start(which, 1'b0);
        1:       set_start(which, 1'b1);
        default: set_start(which, 1'($urandom_range(0, 1)));
      endcase
      if (c == abort_at) begin
        set_rst(which, 1'b1);
        @(posedge clk); #1;
        zero_chk(which, $sformatf("L%0d abort c%0d", lat, c));
        set_rst(which, 1'b0);
        set_start(which, 1'b0);
        return;
      end
    end
    @(posedge clk); #1;
    sample(which, o);
    t = $sformatf("L%0d done-cycle", lat);
    chk({t, " busy"}, o.busy, 0);
    chk({t, " done"}, o.done, 1);
    chk({t, " we"}, o.we, 0);
    chk({t, " rd_valid"}, o.rd_valid, 0);
    chk({t, " busy_count"}, busy_cnt, (lat == 1) ? 36 : 44);
    chk({t, " we_count"}, we_cnt, N_LOG * NB);
    set_start(which, (mode != 0) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    sample(which, o);
    chk($sformatf("L%0d post-done busy", lat), o.busy, 0);
    chk($sformatf("L%0d post-done done", lat), o.done, 0);
    set_start(which, 1'b0);
    @(posedge clk); #1;
    sample(which, o);
    chk($sformatf("L%0d idle busy", lat), o.busy, 0);
    chk($sformatf("L%0d idle done", lat), o.done, 0);
  endtask

  initial begin
    int ab;
    bus1.iSTART = 1'b0;
    bus3.iSTART = 1'b0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    zero_chk(1, "reset L1");
    zero_chk(3, "reset L3");
    rst1 = 1'b0;
    rst3 = 1'b0;
    idle_chk(1, 2, "L1 after reset");

    run_xform(1, 1, 0, -1);
    idle_chk(1, $urandom_range(1, 3), "L1 gap a");
    run_xform(1, 1, 1, -1);
    run_xform(1, 1, 2, -1);
    idle_chk(1, $urandom_range(1, 3), "L1 gap b");

    run_xform(1, 1, 0, (NB + 1) * 1 + 3);
    idle_chk(1, 12, "L1 after abort s1b3");
    run_xform(1, 1, 0, -1);

    ab = $urandom_range(0, N_LOG * (NB + 1) - 1);
    run_xform(1, 1, 2, ab);
    idle_chk(1, 12, "L1 after random abort");
    run_xform(1, 1, 2, -1);

    idle_chk(3, 2, "L3 start");
    run_xform(3, 3, 0, -1);
    run_xform(3, 3, 2, -1);
    ab = $urandom_range(0, N_LOG * (NB + 3) - 1);
    run_xform(3, 3, 1, ab);
    idle_chk(3, 12, "L3 after random abort");
    run_xform(3, 3, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
